// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: data widths, fetch
// constants and the instruction-queue entry layout.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits carry no meaning.
    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a single-cycle
// flush. Pointers wrap naturally because DEPTH is a power of two.
module instr_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q,  count_d;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush wins over a same-cycle push or pop so no wrong-path entry survives.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_push = push_i;
            do_pop  = pop_i & ~empty_o;
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the PC, issues one-cycle-latency reads to
// the instruction RAM and buffers returned words for the issue stage.
module fetch_prefetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_fetch_i,
    input  logic [31:0]                redirect_pc_fetch_i,
    output logic [31:0]                addr_imem_fetch_o,
    output logic                       rd_en_imem_fetch_o,
    input  logic [31:0]                instr_imem_fetch_i,
    output logic                       valid_fetch_o,
    input  logic                       ready_fetch_i,
    output logic [31:0]                instr_fetch_o,
    output logic [31:0]                pc_fetch_o,
    output logic [31:0]                next_pc_fetch_o,
    output logic [$clog2(DEPTH):0]     count_fetch_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;

    logic [XLEN-1:0]    fetch_addr;
    logic               rd_en;
    logic [CW:0]        credit_used;
    logic               q_push;
    logic               q_pop;
    logic               q_empty;
    logic               q_full;
    logic [CW-1:0]      q_count;
    fetch_entry_t       q_wdata;
    fetch_entry_t       q_head;

    // Outstanding work is queued entries plus the read still in flight; the
    // same-cycle pop is deliberately not credited back.
    assign credit_used = {1'b0, q_count} + (CW+1)'(inflight_q);

    always_comb begin
        fetch_addr    = redirect_fetch_i ? pc_align(redirect_pc_fetch_i) : pc_q;
        rd_en         = reset & (redirect_fetch_i | (credit_used < (CW+1)'(DEPTH)));
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (rd_en) begin
            pc_d          = fetch_addr + PC_INC;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_addr;
        end
    end

    // Redirect discards both the returning stale word and any head handshake.
    always_comb begin
        q_push        = inflight_q & ~redirect_fetch_i & ~q_full;
        q_pop         = ~q_empty & ready_fetch_i & ~redirect_fetch_i;
        q_wdata.instr = instr_imem_fetch_i;
        q_wdata.pc    = inflight_pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    instr_queue #(
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect_fetch_i),
        .wdata_i (q_wdata),
        .head_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    always_comb begin
        addr_imem_fetch_o  = fetch_addr;
        rd_en_imem_fetch_o = rd_en;
        valid_fetch_o      = ~q_empty;
        count_fetch_o      = q_count;
        instr_fetch_o      = INSTR_NOP;
        pc_fetch_o         = '0;
        next_pc_fetch_o    = '0;
        if (!q_empty) begin
            instr_fetch_o   = q_head.instr;
            pc_fetch_o      = q_head.pc;
            next_pc_fetch_o = q_head.pc + PC_INC;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a registered RAM model, a PC
// scoreboard that drives ready while work is expected, and cycle-exact checks.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic           clk;
    logic           reset;
    logic           redirect_fetch;
    logic [31:0]    redirect_pc_fetch;
    logic [31:0]    addr_imem;
    logic           rd_en_imem;
    logic [31:0]    instr_imem;
    logic           valid_fetch;
    logic           ready_fetch;
    logic [31:0]    instr_fetch;
    logic [31:0]    pc_fetch;
    logic [31:0]    next_pc_fetch;
    logic [CW-1:0]  count_fetch;

    logic [31:0]    exp_q[$];
    int             err_cnt;
    int             chk_cnt;

    fetch_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .redirect_fetch_i    (redirect_fetch),
        .redirect_pc_fetch_i (redirect_pc_fetch),
        .addr_imem_fetch_o   (addr_imem),
        .rd_en_imem_fetch_o  (rd_en_imem),
        .instr_imem_fetch_i  (instr_imem),
        .valid_fetch_o       (valid_fetch),
        .ready_fetch_i       (ready_fetch),
        .instr_fetch_o       (instr_fetch),
        .pc_fetch_o          (pc_fetch),
        .next_pc_fetch_o     (next_pc_fetch),
        .count_fetch_o       (count_fetch)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", err_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- instruction RAM model ----------------
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    initial instr_imem = 32'h0;
    always @(posedge clk) begin
        if (rd_en_imem) instr_imem <= ram_word(addr_imem);
    end

    // Issue stage accepts only while the scoreboard still expects deliveries.
    always @(posedge clk) begin
        #1;
        ready_fetch = (exp_q.size() != 0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Scoreboard: every accepted head must be the next expected PC.
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (reset === 1'b1) begin
            check("count_bound", 32'(count_fetch <= CW'(DEPTH)), 32'd1);
            if (valid_fetch && ready_fetch && !redirect_fetch) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_pc = exp_q.pop_front();
                    check("acc_pc", pc_fetch, exp_pc);
                    check("acc_next_pc", next_pc_fetch, exp_pc + 32'd4);
                    check("acc_instr", instr_fetch, ram_word(exp_pc));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_seq(input logic [31:0] first, input int n);
        logic [31:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic wait_drain(input int budget);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            step();
            cyc++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        err_cnt           = 0;
        chk_cnt           = 0;
        reset             = 1'b0;
        redirect_fetch    = 1'b0;
        redirect_pc_fetch = 32'h0;
        ready_fetch       = 1'b0;

        // Reset state
        step();
        step();
        sample();
        check("rst_rd_en", 32'(rd_en_imem), 32'd0);
        check("rst_addr", addr_imem, RESET_PC);
        check("rst_valid", 32'(valid_fetch), 32'd0);
        check("rst_instr", instr_fetch, 32'h0);
        check("rst_pc", pc_fetch, 32'h0);
        check("rst_next_pc", next_pc_fetch, 32'h0);
        check("rst_count", 32'(count_fetch), 32'd0);

        // 1. Startup fetch: 0,4,8,... with valid from c2
        expect_seq(32'h0, 8);
        step();
        reset = 1'b1;
        sample();
        check("c0_rd_en", 32'(rd_en_imem), 32'd1);
        check("c0_addr", addr_imem, 32'h0);
        check("c0_valid", 32'(valid_fetch), 32'd0);
        step();
        sample();
        check("c1_addr", addr_imem, 32'h4);
        check("c1_valid", 32'(valid_fetch), 32'd0);
        step();
        sample();
        check("c2_valid", 32'(valid_fetch), 32'd1);
        check("c2_addr", addr_imem, 32'h8);
        wait_drain(40);

        // 2. Back-pressure: reads stop at DEPTH outstanding, then resume
        repeat (10) step();
        sample();
        check("bp_rd_en_low", 32'(rd_en_imem), 32'd0);
        check("bp_count_full", 32'(count_fetch), 32'd4);
        check("bp_head_pc", pc_fetch, 32'h20);
        step();
        expect_seq(32'h20, 12);
        step();
        sample();
        check("bp_ready_up", 32'(ready_fetch), 32'd1);
        check("bp_no_bypass", 32'(rd_en_imem), 32'd0);
        step();
        sample();
        check("bp_resume_rd", 32'(rd_en_imem), 32'd1);
        check("bp_resume_addr", addr_imem, 32'h30);
        wait_drain(60);

        // 3. Redirect with count=3 and a read in flight
        repeat (10) step();
        expect_seq(32'h50, 1);
        step();
        step();
        sample();
        check("rd3_inflight_rd", 32'(rd_en_imem), 32'd1);
        check("rd3_inflight_addr", addr_imem, 32'h60);
        step();
        redirect_fetch    = 1'b1;
        redirect_pc_fetch = 32'h0000_0100;
        sample();
        check("rd3_r_count", 32'(count_fetch), 32'd3);
        check("rd3_r_rd_en", 32'(rd_en_imem), 32'd1);
        check("rd3_r_addr", addr_imem, 32'h100);
        step();
        redirect_fetch = 1'b0;
        sample();
        check("rd3_r1_count", 32'(count_fetch), 32'd0);
        check("rd3_r1_valid", 32'(valid_fetch), 32'd0);
        check("rd3_r1_addr", addr_imem, 32'h104);
        step();
        sample();
        check("rd3_r2_valid", 32'(valid_fetch), 32'd1);
        check("rd3_r2_pc", pc_fetch, 32'h100);
        expect_seq(32'h100, 4);
        wait_drain(30);

        // 6. Redirect in the same cycle as a handshake: head is discarded
        repeat (10) step();
        expect_seq(32'h200, 3);
        step();
        redirect_fetch    = 1'b1;
        redirect_pc_fetch = 32'h0000_0200;
        sample();
        check("rh_valid", 32'(valid_fetch), 32'd1);
        check("rh_ready", 32'(ready_fetch), 32'd1);
        check("rh_head_pc", pc_fetch, 32'h110);
        check("rh_addr", addr_imem, 32'h200);
        step();
        redirect_fetch = 1'b0;
        sample();
        check("rh_r1_valid", 32'(valid_fetch), 32'd0);
        check("rh_r1_count", 32'(count_fetch), 32'd0);
        wait_drain(30);

        // 4. PC wrap: unaligned target is forced down, then wraps to 0
        repeat (4) step();
        expect_seq(32'hFFFF_FFFC, 3);
        redirect_fetch    = 1'b1;
        redirect_pc_fetch = 32'hFFFF_FFFF;
        sample();
        check("wrap_addr", addr_imem, 32'hFFFF_FFFC);
        step();
        redirect_fetch = 1'b0;
        sample();
        check("wrap_addr_next", addr_imem, 32'h0000_0000);
        step();
        sample();
        check("wrap_head_pc", pc_fetch, 32'hFFFF_FFFC);
        check("wrap_head_next_pc", next_pc_fetch, 32'h0000_0000);
        wait_drain(30);

        // 5. Reset mid-stream with count=3
        repeat (6) step();
        expect_seq(32'h8, 1);
        step();
        step();
        sample();
        check("mr_count_pre", 32'(count_fetch), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        check("mr_valid", 32'(valid_fetch), 32'd0);
        check("mr_count", 32'(count_fetch), 32'd0);
        check("mr_rd_en", 32'(rd_en_imem), 32'd0);
        check("mr_addr", addr_imem, RESET_PC);
        check("mr_instr", instr_fetch, 32'h0);
        step();
        step();
        expect_seq(RESET_PC, 4);
        reset = 1'b1;
        sample();
        check("mr_c0_rd_en", 32'(rd_en_imem), 32'd1);
        check("mr_c0_addr", addr_imem, RESET_PC);
        step();
        step();
        sample();
        check("mr_c2_valid", 32'(valid_fetch), 32'd1);
        check("mr_c2_pc", pc_fetch, RESET_PC);
        wait_drain(30);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
